// File: rtl/jaa_pkg.sv
// Shared definitions for the bytecode fetch path: opcode constants, halt opcode
// list and the fetch FSM state encoding.
package jaa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  localparam logic [7:0] OP_BIPUSH  = 8'h10;
  localparam logic [7:0] OP_ILOAD   = 8'h15;
  localparam logic [7:0] OP_ISTORE  = 8'h36;
  localparam logic [7:0] OP_SIPUSH  = 8'h11;
  localparam logic [7:0] OP_IINC    = 8'h84;
  localparam logic [7:0] OP_IRETURN = 8'hAC;
  localparam logic [7:0] OP_RETURN  = 8'hB1;

  localparam int N_HALT_OPS = 2;
  localparam logic [7:0] HALT_OPS [N_HALT_OPS] = '{OP_IRETURN, OP_RETURN};

  function automatic logic is_halt_op(input logic [7:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_HALT_OPS; i++) begin
      if (op == HALT_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/jaa_bc_len.sv
// Opcode classifier: number of operand bytes that follow, and whether the
// opcode ends the program. Opcodes not listed take no operands.
module jaa_bc_len
  import jaa_pkg::*;
(
  input  logic [7:0] opcode_i,
  output logic [1:0] nargs_o,
  output logic       is_halt_o
);

  always_comb begin
    nargs_o = 2'd0;
    unique case (opcode_i)
      OP_BIPUSH, OP_ILOAD, OP_ISTORE: nargs_o = 2'd1;
      OP_SIPUSH, OP_IINC:             nargs_o = 2'd2;
      default:                        nargs_o = 2'd0;
    endcase
  end

  assign is_halt_o = is_halt_op(opcode_i);

endmodule

// File: rtl/bytecode_fetch.sv
// Fetches bytecode from a registered-read ROM, gathers operand bytes and
// presents one complete instruction at a time on a valid/ready port.
module bytecode_fetch
  import jaa_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  bc_valid,
  input  logic                  bc_ready,
  output logic [7:0]            bc_opcode,
  output logic [15:0]           bc_operand,
  output logic [1:0]            bc_nargs,
  output logic [ADDR_WIDTH-1:0] bc_pc,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            dbg_state
);

  // Handshake: bc_valid is high only in PRESENT and the payload is frozen there;
  // a transfer happens on a rising edge with bc_valid and bc_ready both high.

  localparam logic [ADDR_WIDTH-1:0] PC_MAX = {ADDR_WIDTH{1'b1}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [7:0]            opcode_q, opcode_d;
  logic [15:0]           operand_q, operand_d;
  logic [1:0]            nargs_q, nargs_d;
  logic [ADDR_WIDTH-1:0] bcpc_q, bcpc_d;
  logic [1:0]            rem_q, rem_d;
  logic                  op_phase_q, op_phase_d;
  logic                  halt_q, halt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [7:0] rom_byte;
  logic [1:0] len_nargs;
  logic       len_halt;
  logic [1:0] rem_next;

  assign rom_byte = rom_data[7:0];

  jaa_bc_len u_len (
    .opcode_i  (rom_byte),
    .nargs_o   (len_nargs),
    .is_halt_o (len_halt)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    nargs_d    = nargs_q;
    bcpc_d     = bcpc_q;
    rem_d      = rem_q;
    op_phase_d = op_phase_q;
    halt_d     = halt_q;
    done_d     = done_q;
    err_d      = err_q;
    rem_next   = rem_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d       = '0;
          op_phase_d = 1'b1;
          state_d    = ST_ISSUE;
        end
      end

      ST_ISSUE: state_d = ST_CAPT;

      ST_CAPT: begin
        if (op_phase_q) begin
          opcode_d  = rom_byte;
          bcpc_d    = pc_q;
          nargs_d   = len_nargs;
          halt_d    = len_halt;
          operand_d = 16'h0000;
          rem_next  = len_nargs;
        end else begin
          operand_d = {operand_q[7:0], rom_byte};
          rem_next  = rem_q - 2'd1;
        end
        rem_d      = rem_next;
        op_phase_d = 1'b0;
        if (rem_next != 2'd0) begin
          // An operand byte past the end of the ROM is an overrun, not a wrap.
          if (pc_q == PC_MAX) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_PRESENT;
        end
      end

      ST_PRESENT: begin
        if (bc_ready) begin
          if (halt_q) begin
            done_d  = 1'b1;
            state_d = ST_HALT;
          end else if (pc_q == PC_MAX) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d       = pc_q + 1'b1;
            op_phase_d = 1'b1;
            state_d    = ST_ISSUE;
          end
        end
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      opcode_q   <= '0;
      operand_q  <= '0;
      nargs_q    <= '0;
      bcpc_q     <= '0;
      rem_q      <= '0;
      op_phase_q <= 1'b1;
      halt_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      nargs_q    <= nargs_d;
      bcpc_q     <= bcpc_d;
      rem_q      <= rem_d;
      op_phase_q <= op_phase_d;
      halt_q     <= halt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rom_addr   = pc_q;
  assign bc_valid   = (state_q == ST_PRESENT);
  assign bc_opcode  = opcode_q;
  assign bc_operand = operand_q;
  assign bc_nargs   = nargs_q;
  assign bc_pc      = bcpc_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dbg_state  = state_q;

endmodule
